// File: rtl/vid_stream_pkg.sv
// Shared pixel types, RGB888->RGB555 pack and stream FSM states for the
// camera-side video blocks.
package vid_stream_pkg;

  typedef struct packed {
    logic [7:0] r;
    logic [7:0] g;
    logic [7:0] b;
  } rgb888_t;

  typedef struct packed {
    logic [4:0] r;
    logic [4:0] g;
    logic [4:0] b;
  } rgb555_t;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACTIVE = 2'd1,
    DONE   = 2'd2
  } state_t;

  // Plain truncation to the 5 MSBs of each channel.
  function automatic rgb555_t rgb888_to_555(input rgb888_t p);
    rgb555_t q;
    q.r = p.r[7:3];
    q.g = p.g[7:3];
    q.b = p.b[7:3];
    return q;
  endfunction

endpackage

// File: rtl/vid_xy_counter.sv
// Pixel position counter: x wraps at LINE_W, y saturates at FRAME_H-1.
// x/y are the coordinates of the pixel currently presented; clr forces (0,0).
module vid_xy_counter #(
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480,
  parameter int CW      = 11
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          clr,
  input  logic          en,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y
);

  logic [CW-1:0] x_q, y_q;

  assign x = clr ? '0 : x_q;
  assign y = clr ? '0 : y_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      x_q <= '0;
      y_q <= '0;
    end else if (en) begin
      if (x == CW'(LINE_W - 1)) begin
        x_q <= '0;
        y_q <= (y == CW'(FRAME_H - 1)) ? y : y + 1'b1;
      end else begin
        x_q <= x + 1'b1;
        y_q <= y;
      end
    end
  end

endmodule

// File: rtl/mipi_window_crop.sv
// Crops a window out of the camera stream and packs survivors to RGB555.
// Window cfg is latched on frame start so a frame is never torn.
module mipi_window_crop
  import vid_stream_pkg::*;
#(
  parameter int LINE_W  = 640,
  parameter int FRAME_H = 480,
  parameter int CW      = 11
) (
  input  logic          iCLK,
  input  logic          iRESET,
  input  logic [23:0]   iDATA,
  input  logic          iDV,
  input  logic          iSTART,
  input  logic [CW-1:0] iX0,
  input  logic [CW-1:0] iY0,
  input  logic [CW-1:0] iW,
  input  logic [CW-1:0] iH,
  output logic [14:0]   oDATA,
  output logic          oDV,
  output logic          oSTART,
  output logic          oFRAME_DONE,
  output logic          oCFG_ERR
);

  localparam logic [CW:0] ONE = (CW+1)'(1);

  logic          sof;
  logic [CW-1:0] px, py;
  logic [CW-1:0] x0_q, y0_q, w_q, h_q;
  logic [CW-1:0] x0, y0, w, h;
  logic [CW:0]   x_end, y_end;
  logic          cfg_ok, first_q, first_eff, in_win, pass, last;
  state_t        state, st_eff;

  assign sof = iSTART & iDV;

  vid_xy_counter #(
    .LINE_W (LINE_W),
    .FRAME_H(FRAME_H),
    .CW     (CW)
  ) u_xy (
    .clk(iCLK),
    .rst(iRESET),
    .clr(sof),
    .en (iDV),
    .x  (px),
    .y  (py)
  );

  // The start pixel itself is judged against the cfg being latched with it.
  always_comb begin
    x0 = sof ? iX0 : x0_q;
    y0 = sof ? iY0 : y0_q;
    w  = sof ? iW  : w_q;
    h  = sof ? iH  : h_q;
  end

  assign x_end  = {1'b0, x0} + {1'b0, w};
  assign y_end  = {1'b0, y0} + {1'b0, h};
  assign cfg_ok = (w != '0) && (h != '0) &&
                  (x_end <= (CW+1)'(LINE_W)) && (y_end <= (CW+1)'(FRAME_H));

  always_comb begin
    st_eff    = state;
    first_eff = first_q;
    if (sof) begin
      st_eff    = cfg_ok ? ACTIVE : DONE;
      first_eff = 1'b1;
    end
  end

  assign in_win = (px >= x0) && ({1'b0, px} < x_end) &&
                  (py >= y0) && ({1'b0, py} < y_end);
  assign pass   = iDV && (st_eff == ACTIVE) && in_win;
  assign last   = pass && ({1'b0, px} == x_end - ONE) && ({1'b0, py} == y_end - ONE);

  always_ff @(posedge iCLK) begin
    if (iRESET) begin
      state       <= IDLE;
      first_q     <= 1'b0;
      x0_q        <= '0;
      y0_q        <= '0;
      w_q         <= '0;
      h_q         <= '0;
      oDATA       <= '0;
      oDV         <= 1'b0;
      oSTART      <= 1'b0;
      oFRAME_DONE <= 1'b0;
      oCFG_ERR    <= 1'b0;
    end else begin
      if (sof) begin
        x0_q <= iX0;
        y0_q <= iY0;
        w_q  <= iW;
        h_q  <= iH;
        if (!cfg_ok) oCFG_ERR <= 1'b1;
      end
      state       <= last ? DONE : st_eff;
      first_q     <= first_eff & ~pass;
      oDV         <= pass;
      oDATA       <= pass ? rgb888_to_555(iDATA) : '0;
      oSTART      <= pass & first_eff;
      oFRAME_DONE <= last;
    end
  end

endmodule

// File: tb/tb_mipi_window_crop.sv
// Directed bench for mipi_window_crop on a reduced 128x64 raster so every
// scenario, including full frames, stays short.
module tb_mipi_window_crop;

  localparam int LW = 128;
  localparam int FH = 64;
  localparam int CW = 11;

  logic          iCLK = 1'b0;
  logic          iRESET;
  logic [23:0]   iDATA;
  logic          iDV, iSTART;
  logic [CW-1:0] iX0, iY0, iW, iH;
  logic [14:0]   oDATA;
  logic          oDV, oSTART, oFRAME_DONE, oCFG_ERR;

  mipi_window_crop #(.LINE_W(LW), .FRAME_H(FH), .CW(CW)) dut (
    .iCLK(iCLK), .iRESET(iRESET), .iDATA(iDATA), .iDV(iDV), .iSTART(iSTART),
    .iX0(iX0), .iY0(iY0), .iW(iW), .iH(iH),
    .oDATA(oDATA), .oDV(oDV), .oSTART(oSTART), .oFRAME_DONE(oFRAME_DONE),
    .oCFG_ERR(oCFG_ERR)
  );

  always #5 iCLK = ~iCLK;

  int n_chk = 0, n_err = 0;

  task automatic chk(input string tag, input longint act, input longint exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, act, exp);
    end
  endtask

  function automatic logic [14:0] pack(input logic [23:0] d);
    return {d[23:19], d[15:11], d[7:3]};
  endfunction

  // Stimulus-side position of the pixel on the inputs, and expected window.
  int cur_x = 0, cur_y = 0;
  int ex0 = 0, ey0 = 0, ew = 0, eh = 0;

  // Input history one cycle back, lined up with the registered outputs.
  logic        h_dv = 1'b0;
  logic [23:0] h_d  = '0;
  int          h_x = 0, h_y = 0;
  always @(posedge iCLK) begin
    h_dv <= iDV;
    h_d  <= iDATA;
    h_x  <= cur_x;
    h_y  <= cur_y;
  end

  int n_dv = 0, n_st = 0, n_dn = 0, n_lat = 0, n_dat = 0, n_out = 0;
  int st_x = -1, st_y = -1, dn_x = -1, dn_y = -1;
  always @(negedge iCLK) begin
    if (!iRESET) begin
      if (oDV) begin
        n_dv++;
        if (!h_dv) n_lat++;
        if (oDATA !== pack(h_d)) n_dat++;
        if (!(h_x >= ex0 && h_x < ex0 + ew && h_y >= ey0 && h_y < ey0 + eh)) n_out++;
      end
      if (oSTART) begin
        n_st++; st_x = h_x; st_y = h_y;
        if (!oDV) n_lat++;
      end
      if (oFRAME_DONE) begin
        n_dn++; dn_x = h_x; dn_y = h_y;
        if (!oDV) n_lat++;
      end
    end
  end

  int s_dv, s_st, s_dn, s_lat, s_dat, s_out;
  task automatic snap();
    s_dv = n_dv; s_st = n_st; s_dn = n_dn; s_lat = n_lat; s_dat = n_dat; s_out = n_out;
  endtask

  task automatic idle(input int n);
    @(posedge iCLK); #1;
    iDV = 1'b0; iSTART = 1'b0;
    repeat (n) @(posedge iCLK);
    #1;
  endtask

  // One frame from (0,0): start pixel carries cfg, then npix-1 more pixels.
  task automatic run(input int x0, input int y0, input int w, input int h,
                     input int npix, input int gap, input int chg_at, input int chg_x0);
    for (int i = 0; i < npix; i++) begin
      @(posedge iCLK); #1;
      if (i == 0) begin
        iX0 = CW'(x0); iY0 = CW'(y0); iW = CW'(w); iH = CW'(h);
        ex0 = x0; ey0 = y0; ew = w; eh = h;
      end
      if (i == chg_at) iX0 = CW'(chg_x0);
      iSTART = (i == 0);
      iDV    = 1'b1;
      iDATA  = 24'($urandom);
      cur_x  = i % LW;
      cur_y  = (i / LW < FH) ? i / LW : FH - 1;
      for (int g = 0; g < gap; g++) begin
        @(posedge iCLK); #1;
        iDV = 1'b0; iSTART = 1'b0;
      end
    end
    idle(2);
  endtask

  task automatic chk_frame(input string t, input int dv, input int st, input int dn);
    chk({t, "_dv"}, n_dv - s_dv, dv);
    chk({t, "_start_cnt"}, n_st - s_st, st);
    chk({t, "_done_cnt"}, n_dn - s_dn, dn);
    chk({t, "_latency"}, n_lat - s_lat, 0);
    chk({t, "_data"}, n_dat - s_dat, 0);
    chk({t, "_outside"}, n_out - s_out, 0);
  endtask

  initial begin
    iRESET = 1'b1; iDV = 1'b0; iSTART = 1'b0; iDATA = '0;
    iX0 = '0; iY0 = '0; iW = '0; iH = '0;
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_odv", oDV, 0);
    chk("rst_ostart", oSTART, 0);
    chk("rst_done", oFRAME_DONE, 0);
    chk("rst_err", oCFG_ERR, 0);
    chk("rst_odata", oDATA, 0);
    iRESET = 1'b0;

    // IDLE: pixels without a start pass nothing.
    snap();
    iX0 = '0; iY0 = '0; iW = CW'(LW); iH = CW'(FH);
    for (int i = 0; i < 10; i++) begin
      @(posedge iCLK); #1; iDV = 1'b1; iDATA = 24'($urandom);
    end
    idle(2);
    chk("idle_dv", n_dv - s_dv, 0);

    // Full-raster window, plus a long tail into the saturated last line.
    snap();
    run(0, 0, LW, FH, LW * FH + 130, 0, -1, 0);
    chk_frame("full", LW * FH, 1, 1);
    chk("full_st_xy", st_x * 1000 + st_y, 0);
    chk("full_dn_xy", dn_x * 1000 + dn_y, 127063);

    // 4x2 window at (100,50), frame runs on past the window.
    snap();
    run(100, 50, 4, 2, 51 * LW + 104 + 200, 0, -1, 0);
    chk_frame("win", 8, 1, 1);
    chk("win_st_xy", st_x * 1000 + st_y, 100050);
    chk("win_dn_xy", dn_x * 1000 + dn_y, 103051);

    // iX0 changes mid-frame: this frame keeps 100, next frame picks up 20.
    snap();
    run(100, 50, 4, 2, 51 * LW + 104, 0, 10, 20);
    chk_frame("chg_cur", 8, 1, 1);
    chk("chg_cur_dn_xy", dn_x * 1000 + dn_y, 103051);
    snap();
    run(20, 50, 4, 2, 51 * LW + 24, 0, -1, 0);
    chk_frame("chg_next", 8, 1, 1);
    chk("chg_next_st_xy", st_x * 1000 + st_y, 20050);

    // Resync at (100,10) of a running frame with a new cfg.
    snap();
    run(0, 5, LW, 10, 10 * LW + 100, 0, -1, 0);
    chk_frame("resync_a", 5 * LW + 100, 1, 0);
    snap();
    run(10, 5, 3, 2, 6 * LW + 13, 0, -1, 0);
    chk_frame("resync_b", 6, 1, 1);
    chk("resync_st_xy", st_x * 1000 + st_y, 10005);
    chk("resync_dn_xy", dn_x * 1000 + dn_y, 12006);

    // Window touching the far corner is still legal.
    snap();
    run(LW - 4, FH - 1, 4, 1, LW * FH, 0, -1, 0);
    chk_frame("corner", 4, 1, 1);
    chk("corner_dn_xy", dn_x * 1000 + dn_y, 127063);
    chk("corner_err", oCFG_ERR, 0);

    // Invalid cfgs drop the frame and leave oCFG_ERR sticky.
    snap();
    run(10, 0, 0, 2, 300, 0, -1, 0);
    chk_frame("w0", 0, 0, 0);
    chk("w0_err", oCFG_ERR, 1);
    snap();
    run(100, 0, 40, 1, 300, 0, -1, 0);
    chk_frame("xover", 0, 0, 0);
    snap();
    run(5, 1, 3, 1, LW + 10, 0, -1, 0);
    chk_frame("after_err", 3, 1, 1);
    chk("after_err_dn_xy", dn_x * 1000 + dn_y, 7001);
    chk("after_err_sticky", oCFG_ERR, 1);

    // 1-of-3 gapped input.
    snap();
    run(100, 50, 4, 2, 51 * LW + 104, 2, -1, 0);
    chk_frame("gap", 8, 1, 1);
    chk("gap_st_xy", st_x * 1000 + st_y, 100050);
    chk("gap_dn_xy", dn_x * 1000 + dn_y, 103051);

    // Known pack value on a 1x1 window at the origin.
    @(posedge iCLK); #1;
    iX0 = '0; iY0 = '0; iW = CW'(1); iH = CW'(1);
    ex0 = 0; ey0 = 0; ew = 1; eh = 1; cur_x = 0; cur_y = 0;
    iSTART = 1'b1; iDV = 1'b1; iDATA = 24'hFF8040;
    @(posedge iCLK); #1;
    chk("pack_odata", oDATA, 15'h7E08);
    chk("pack_flags", {oDV, oSTART, oFRAME_DONE}, 3'b111);
    iSTART = 1'b0; iDV = 1'b0;
    idle(2);

    // Reset in the middle of a frame.
    run(0, 0, LW, FH, 50, 0, -1, 0);
    @(posedge iCLK); #1;
    iDV = 1'b1; iDATA = 24'($urandom); cur_x = 50; iRESET = 1'b1;
    @(posedge iCLK); #1;
    chk("midrst_odv", oDV, 0);
    chk("midrst_err", oCFG_ERR, 0);
    iRESET = 1'b0;
    snap();
    for (int i = 0; i < 40; i++) begin
      @(posedge iCLK); #1; iDV = 1'b1; iDATA = 24'($urandom);
    end
    idle(2);
    chk("midrst_silent", n_dv - s_dv, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
